// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and receive-handshake outputs of the UART receiver.
// master = the receiver (drives the byte/pulse/status outputs, reads rx).
// slave  = the line driver / boot loader side.
interface uart_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   modport master (
      input  rx,
      output rx_data, rx_done, frame_err, parity_err, busy
   );

   modport slave (
      output rx,
      input  rx_data, rx_done, frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 8N1 LSB first.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables parity_err;
// without it parity_err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a low level on rx_s
// S_START  | confirming the start bit at its mid-point (sample 7)
// S_DATA   | sampling 8 data bits at mid-bit (sample 15), LSB first
// S_PARITY | sampling the even-parity bit (parity builds only)
// S_STOP   | sampling the stop bit, emitting rx_done / frame_err / parity_err
// S_BREAK  | stop bit was low; waiting for the line to return high
module uart_rx #(
   parameter int CLK_HZ   = 50000000,
   parameter int BAUD     = 115200,
   parameter int TICK_DIV = CLK_HZ / (BAUD * 16)
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_rx_if.master  bus
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   logic          rx_m;
   logic          rx_s;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    samp_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   state_t        state;
   logic [7:0]    rx_data_q;
   logic          rx_done_q;
   logic          frame_err_q;
   logic          busy_q;
`ifdef UART_RX_PARITY_EN
   logic          par_bit;
   logic          parity_err_q;
`endif

   // Two-flop synchronizer on the asynchronous line; resets to the idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= bus.rx;
         rx_s <= rx_m;
      end
   end

   // Oversample tick: down-counter that fires and reloads at terminal count 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick_cnt == '0) begin
         tick_cnt <= TICK_RELOAD;
      end else begin
         tick_cnt <= tick_cnt - 1'b1;
      end
   end

   assign tick = (tick_cnt == '0);

   // Receive FSM with sample counter, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         samp_cnt    <= 4'd0;
         bit_idx     <= 3'd0;
         shreg       <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         // free-running; the clears below take precedence
         if (tick) samp_cnt <= samp_cnt + 4'd1;

         case (state)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (!rx_s) begin
                  samp_cnt <= 4'd0;
                  busy_q   <= 1'b1;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (tick && samp_cnt == 4'd7) begin
                  if (!rx_s) begin
                     samp_cnt <= 4'd0;
                     bit_idx  <= 3'd0;
                     state    <= S_DATA;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (tick && samp_cnt == 4'd15) begin
                  shreg[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick && samp_cnt == 4'd15) begin
                  par_bit <= rx_s;
                  state   <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               // leave at mid-stop so a following start edge is never missed
               if (tick && samp_cnt == 4'd15) begin
                  if (!rx_s) begin
                     frame_err_q <= 1'b1;
                     state       <= S_BREAK;
`ifdef UART_RX_PARITY_EN
                  end else if (^{shreg, par_bit}) begin
                     parity_err_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state        <= S_IDLE;
`endif
                  end else begin
                     rx_data_q <= shreg;
                     rx_done_q <= 1'b1;
                     busy_q    <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_done   = rx_done_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clk per bit (TICK_DIV=1).
module tb_uart_rx;

   localparam int CLK_HZ = 1843200;
   localparam int BAUD   = 115200;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_CLK = 176;
`else
   localparam int FRAME_CLK = 160;
`endif

   logic clk;
   logic rst_n;

   uart_rx_if bus ();

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;

   int          done_cnt = 0;
   int          ferr_cnt = 0;
   int          perr_cnt = 0;
   int          excl_viol = 0;
   longint      cyc = 0;
   logic [7:0]  hist [0:15];
   longint      done_cyc [0:15];
   logic        busy_at_done = 1'b1;
   logic        prev_busy_at_done = 1'b0;
   logic        prev_busy = 1'b0;
   logic        prev_pulse = 1'b0;
   logic        busy_seen = 1'b0;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      int np;
      cyc = cyc + 1;
      np = int'(bus.rx_done) + int'(bus.frame_err) + int'(bus.parity_err);
      if (np > 1 || (np != 0 && prev_pulse)) excl_viol = excl_viol + 1;
      if (bus.rx_done === 1'b1) begin
         hist[done_cnt & 15]     = bus.rx_data;
         done_cyc[done_cnt & 15] = cyc;
         busy_at_done            = bus.busy;
         prev_busy_at_done       = prev_busy;
         done_cnt                = done_cnt + 1;
      end
      if (bus.frame_err === 1'b1)  ferr_cnt = ferr_cnt + 1;
      if (bus.parity_err === 1'b1) perr_cnt = perr_cnt + 1;
      if (bus.busy === 1'b1) busy_seen = 1'b1;
      prev_busy  = bus.busy;
      prev_pulse = (np != 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      bus.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.rx = b;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bx) send_bit(1'b1);
`endif
      send_bit(stop);
   endtask

   int d0, f0, p0;

   initial begin
      bus.rx = 1'b1;
      rst_n  = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_rx_data",    32'(bus.rx_data),    32'h00);
      check("reset_rx_done",    32'(bus.rx_done),    32'h0);
      check("reset_frame_err",  32'(bus.frame_err),  32'h0);
      check("reset_parity_err", 32'(bus.parity_err), 32'h0);
      check("reset_busy",       32'(bus.busy),       32'h0);
      rst_n = 1'b1;
      idle(20);

      // single byte 0xA5
      send_frame(8'hA5, ^8'hA5, 1'b1);
      idle(20);
      check("a5_done_cnt",      32'(done_cnt),          32'd1);
      check("a5_data_pulse",    32'(hist[0]),           32'hA5);
      check("a5_rx_data",       32'(bus.rx_data),       32'hA5);
      check("a5_no_ferr",       32'(ferr_cnt),          32'd0);
      check("a5_busy_at_done",  32'(busy_at_done),      32'h0);
      check("a5_busy_before",   32'(prev_busy_at_done), 32'h1);

      // stop bit low, line held low 40 bit times, then 0x12
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, ^8'h3C, 1'b0);
      bus.rx = 1'b0;
      repeat (40 * 16) @(negedge clk);
      check("brk_busy_held",    32'(bus.busy),          32'h1);
      idle(20);
      check("brk_one_ferr",     32'(ferr_cnt - f0),     32'd1);
      check("brk_no_done",      32'(done_cnt - d0),     32'd0);
      check("brk_rx_data_kept", 32'(bus.rx_data),       32'hA5);
      check("brk_busy_idle",    32'(bus.busy),          32'h0);
      send_frame(8'h12, ^8'h12, 1'b1);
      idle(20);
      check("post_brk_done",    32'(done_cnt - d0),     32'd1);
      check("post_brk_data",    32'(bus.rx_data),       32'h12);

      // back-to-back 0x00, 0xFF with no idle gap
      d0 = done_cnt;
      send_frame(8'h00, ^8'h00, 1'b1);
      send_frame(8'hFF, ^8'hFF, 1'b1);
      idle(20);
      check("b2b_done_cnt",     32'(done_cnt - d0),     32'd2);
      check("b2b_first",        32'(hist[d0 & 15]),     32'h00);
      check("b2b_second",       32'(hist[(d0 + 1) & 15]), 32'hFF);
      check("b2b_spacing",      32'(done_cyc[(d0 + 1) & 15] - done_cyc[d0 & 15]), 32'(FRAME_CLK));
      check("b2b_rx_data",      32'(bus.rx_data),       32'hFF);

      // 4-clk glitch: false start
      d0 = done_cnt; f0 = ferr_cnt;
      busy_seen = 1'b0;
      bus.rx = 1'b0;
      repeat (4) @(negedge clk);
      bus.rx = 1'b1;
      repeat (8) @(negedge clk);
      check("glitch_busy_seen", 32'(busy_seen),         32'h1);
      check("glitch_busy_off",  32'(bus.busy),          32'h0);
      idle(20);
      check("glitch_no_done",   32'(done_cnt - d0),     32'd0);
      check("glitch_no_ferr",   32'(ferr_cnt - f0),     32'd0);

      // reset during bit 4 of 0x55, then 0x81
      d0 = done_cnt; f0 = ferr_cnt;
      begin
         logic [7:0] b55;
         b55 = 8'h55;
         send_bit(1'b0);
         for (int i = 0; i < 4; i++) send_bit(b55[i]);
         bus.rx = b55[4];
         repeat (8) @(negedge clk);
      end
      rst_n  = 1'b0;
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_rx_data",  32'(bus.rx_data),       32'h00);
      check("mid_rst_rx_done",  32'(bus.rx_done),       32'h0);
      check("mid_rst_ferr",     32'(bus.frame_err),     32'h0);
      check("mid_rst_perr",     32'(bus.parity_err),    32'h0);
      check("mid_rst_busy",     32'(bus.busy),          32'h0);
      rst_n = 1'b1;
      idle(40);
      check("mid_rst_no_done",  32'(done_cnt - d0),     32'd0);
      check("mid_rst_no_ferr",  32'(ferr_cnt - f0),     32'd0);
      send_frame(8'h81, ^8'h81, 1'b1);
      idle(20);
      check("after_rst_done",   32'(done_cnt - d0),     32'd1);
      check("after_rst_data",   32'(bus.rx_data),       32'h81);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit must be 1
      d0 = done_cnt; p0 = perr_cnt;
      send_frame(8'h07, 1'b0, 1'b1);
      idle(20);
      check("par_bad_perr",     32'(perr_cnt - p0),     32'd1);
      check("par_bad_no_done",  32'(done_cnt - d0),     32'd0);
      check("par_bad_data",     32'(bus.rx_data),       32'h81);
      send_frame(8'h07, 1'b1, 1'b1);
      idle(20);
      check("par_ok_done",      32'(done_cnt - d0),     32'd1);
      check("par_ok_perr",      32'(perr_cnt - p0),     32'd1);
      check("par_ok_data",      32'(bus.rx_data),       32'h07);
`else
      p0 = 0;
      check("no_parity_pulses", 32'(perr_cnt - p0),     32'd0);
`endif
      check("pulse_exclusive",  32'(excl_viol),         32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
